// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS MEM stage: one word access at a time,
// answered LATENCY cycles after acceptance, with a stall back to the pipeline.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_req_ready,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic        o_stall
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
   localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        r_state;
   logic [3:0]    r_count;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_mem [DEPTH];

   logic          w_misaligned;
   logic          w_oob;
   logic          w_err;
   logic          w_commit;
   logic          w_accept;
   logic [AW-1:0] w_idx;

   assign w_idx        = r_addr[AW+1:2];
   assign w_misaligned = (r_addr[1:0] != 2'b00);
   assign w_oob        = ({1'b0, r_addr} >= ADDR_LIMIT);
   assign w_err        = w_misaligned | w_oob;
   assign w_commit     = (r_state == S_WAIT) && (r_count == 4'd0);
   // The edge that ends the response cycle may already take the next request,
   // which keeps the issue rate at one access per LATENCY+1 cycles.
   assign w_accept     = i_req_valid && ((r_state == S_IDLE) || (r_state == S_RESP));

   assign o_req_ready  = (r_state == S_IDLE);
   assign o_stall      = i_req_valid & ~o_resp_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_count      <= 4'd0;
         r_we         <= 1'b0;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         o_resp_valid <= 1'b0;
         o_resp_rdata <= 32'd0;
         o_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_count != 4'd0) begin
                  r_count <= r_count - 4'd1;
               end else begin
                  r_state      <= S_RESP;
                  o_resp_valid <= 1'b1;
                  o_resp_err   <= w_err;
                  o_resp_rdata <= (!r_we && !w_err) ? r_mem[w_idx] : 32'd0;
               end
            end
            S_RESP: begin
               o_resp_valid <= 1'b0;
               o_resp_rdata <= 32'd0;
               o_resp_err   <= 1'b0;
               r_state      <= i_req_valid ? S_WAIT : S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (w_accept) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_count <= LAT_M1;
         end
      end
   end

   // Storage is deliberately left out of reset; stores land on the RESP-entry edge.
   always_ff @(posedge clk) begin
      if (w_commit && r_we && !w_err) begin
         r_mem[w_idx] <= r_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and LATENCY=1) driven in
// parallel, checked each cycle against a timing/memory model plus literals.
module tb_dmem_responder;

   logic              clk;
   logic              rst_n;
   logic              reqValid;
   logic              reqWe;
   logic [31:0]       reqAddr;
   logic [31:0]       reqWdata;
   logic [1:0]        wReady;
   logic [1:0]        wValid;
   logic [1:0][31:0]  wRdata;
   logic [1:0]        wErr;
   logic [1:0]        wStall;

   int checks = 0;
   int errors = 0;
   bit cmpEn  = 0;

   dmem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(reqValid), .i_req_we(reqWe),
      .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
      .o_req_ready(wReady[0]), .o_resp_valid(wValid[0]),
      .o_resp_rdata(wRdata[0]), .o_resp_err(wErr[0]), .o_stall(wStall[0])
   );

   dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(reqValid), .i_req_we(reqWe),
      .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
      .o_req_ready(wReady[1]), .o_resp_valid(wValid[1]),
      .o_resp_rdata(wRdata[1]), .o_resp_err(wErr[1]), .o_stall(wStall[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: per instance, the accepted request and the edge it was taken on.
   int          mLat [2] = '{2, 1};
   bit          mPend [2];
   longint      mAcc [2];
   logic        mWe [2];
   logic [31:0] mAddr [2];
   logic [31:0] mWdata [2];
   logic [31:0] mMem [2][256];
   bit          mWr [2][256];
   bit          eValid [2];
   logic [31:0] eData [2];
   bit          eErr [2];
   bit          eKnown [2];
   longint      edgeNo = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      reqValid = v;
      reqWe    = we;
      reqAddr  = addr;
      reqWdata = wdata;
   endtask

   // The response for a request accepted on edge A is due on edge A+LATENCY;
   // the earliest following accept is the edge after that.
   initial begin
      bit canAcc;
      bit bad;
      int idx;
      for (int d = 0; d < 2; d++) begin
         mPend[d] = 0; eValid[d] = 0; eData[d] = 0; eErr[d] = 0; eKnown[d] = 1;
         for (int k = 0; k < 256; k++) mWr[d][k] = 0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
               mPend[d] = 0; eValid[d] = 0; eData[d] = 0; eErr[d] = 0; eKnown[d] = 1;
            end
         end else begin
            edgeNo++;
            for (int d = 0; d < 2; d++) begin
               canAcc = !mPend[d];
               eValid[d] = 0; eData[d] = 0; eErr[d] = 0; eKnown[d] = 1;
               if (mPend[d] && edgeNo == mAcc[d] + longint'(mLat[d])) begin
                  bad = (mAddr[d] % 4 != 0) || (mAddr[d] >= 32'd1024);
                  idx = int'(mAddr[d] / 4) % 256;
                  eValid[d] = 1;
                  eErr[d]   = bad;
                  mPend[d]  = 0;
                  if (!bad) begin
                     if (mWe[d]) begin
                        mMem[d][idx] = mWdata[d];
                        mWr[d][idx]  = 1;
                     end else begin
                        eData[d]  = mMem[d][idx];
                        eKnown[d] = mWr[d][idx];
                     end
                  end
               end
               if (canAcc && reqValid) begin
                  mPend[d]  = 1;
                  mAcc[d]   = edgeNo;
                  mWe[d]    = reqWe;
                  mAddr[d]  = reqAddr;
                  mWdata[d] = reqWdata;
               end
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && cmpEn) begin
            for (int d = 0; d < 2; d++) begin
               checkOutput($sformatf("d%0d resp_valid", d), 32'(wValid[d]), 32'(eValid[d]));
               checkOutput($sformatf("d%0d resp_err", d), 32'(wErr[d]), 32'(eErr[d]));
               checkOutput($sformatf("d%0d req_ready", d), 32'(wReady[d]),
                           32'(!mPend[d] && !eValid[d]));
               checkOutput($sformatf("d%0d stall", d), 32'(wStall[d]),
                           32'(reqValid && !eValid[d]));
               if (eKnown[d]) begin
                  checkOutput($sformatf("d%0d resp_rdata", d), wRdata[d], eData[d]);
               end
            end
         end
      end
   end

   task automatic settle();
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      repeat (4) @(posedge clk);
   endtask

   // One access presented for a single cycle while both instances are idle.
   task automatic runAccess(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata,
                            output logic [31:0] rd0, output logic [31:0] rd1,
                            output logic e0, output logic e1);
      @(posedge clk); #1;
      applyStimulus(1'b1, we, addr, wdata);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput({tag, " d0 valid@T"}, 32'(wValid[0]), 32'd0);
      checkOutput({tag, " d1 valid@T"}, 32'(wValid[1]), 32'd0);
      @(negedge clk);
      checkOutput({tag, " d0 valid@T+1"}, 32'(wValid[0]), 32'd0);
      checkOutput({tag, " d1 valid@T+1"}, 32'(wValid[1]), 32'd1);
      rd1 = wRdata[1];
      e1  = wErr[1];
      @(negedge clk);
      checkOutput({tag, " d0 valid@T+2"}, 32'(wValid[0]), 32'd1);
      checkOutput({tag, " d1 valid@T+2"}, 32'(wValid[1]), 32'd0);
      rd0 = wRdata[0];
      e0  = wErr[0];
   endtask

   initial begin
      logic [31:0] rd0, rd1;
      logic        e0, e1;
      logic [31:0] addrTab [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
      int          p0 [$];
      int          p1 [$];

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cmpEn = 1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("reset d%0d ready", d), 32'(wReady[d]), 32'd1);
         checkOutput($sformatf("reset d%0d valid", d), 32'(wValid[d]), 32'd0);
         checkOutput($sformatf("reset d%0d rdata", d), wRdata[d], 32'd0);
         checkOutput($sformatf("reset d%0d err", d), 32'(wErr[d]), 32'd0);
      end

      $display("[TB] store then load at 0x10");
      runAccess("sw10", 1'b1, 32'h10, 32'hDEADBEEF, rd0, rd1, e0, e1);
      checkOutput("sw10 d0 rdata", rd0, 32'd0);
      checkOutput("sw10 d0 err", 32'(e0), 32'd0);
      checkOutput("sw10 d1 rdata", rd1, 32'd0);
      runAccess("lw10", 1'b0, 32'h10, 32'd0, rd0, rd1, e0, e1);
      checkOutput("lw10 d0 rdata", rd0, 32'hDEADBEEF);
      checkOutput("lw10 d1 rdata", rd1, 32'hDEADBEEF);
      checkOutput("lw10 d0 err", 32'(e0), 32'd0);

      $display("[TB] error accesses");
      runAccess("sw00", 1'b1, 32'h0, 32'hCAFEF00D, rd0, rd1, e0, e1);
      runAccess("lw13", 1'b0, 32'h13, 32'd0, rd0, rd1, e0, e1);
      checkOutput("lw13 d0 err", 32'(e0), 32'd1);
      checkOutput("lw13 d0 rdata", rd0, 32'd0);
      runAccess("lw400", 1'b0, 32'h400, 32'd0, rd0, rd1, e0, e1);
      checkOutput("lw400 d0 err", 32'(e0), 32'd1);
      checkOutput("lw400 d1 err", 32'(e1), 32'd1);
      runAccess("sw11", 1'b1, 32'h11, 32'h0BAD0BAD, rd0, rd1, e0, e1);
      checkOutput("sw11 d0 err", 32'(e0), 32'd1);
      runAccess("sw400", 1'b1, 32'h400, 32'h0BAD0BAD, rd0, rd1, e0, e1);
      checkOutput("sw400 d0 err", 32'(e0), 32'd1);
      runAccess("lw10b", 1'b0, 32'h10, 32'd0, rd0, rd1, e0, e1);
      checkOutput("lw10b d0 rdata", rd0, 32'hDEADBEEF);
      runAccess("lw00", 1'b0, 32'h0, 32'd0, rd0, rd1, e0, e1);
      checkOutput("lw00 d0 rdata", rd0, 32'hCAFEF00D);
      checkOutput("lw00 d1 rdata", rd1, 32'hCAFEF00D);
      settle();

      $display("[TB] continuous requests");
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         applyStimulus(1'b1, i[0], addrTab[(i / 2) % 4], 32'hA5A50000 + 32'(i));
         @(negedge clk);
         if (wValid[0]) p0.push_back(i);
         if (wValid[1]) p1.push_back(i);
         if (i < 3) checkOutput($sformatf("held d0 stall c%0d", i), 32'(wStall[0]), 32'd1);
         if (i == 3) begin
            checkOutput("held d0 stall c3", 32'(wStall[0]), 32'd0);
            checkOutput("held d0 rdata c3", wRdata[0], 32'hDEADBEEF);
         end
      end
      settle();
      checkOutput("held d0 pulses", 32'(p0.size()), 32'd3);
      checkOutput("held d1 pulses", 32'(p1.size()), 32'd5);
      for (int k = 1; k < p0.size(); k++)
         checkOutput("held d0 spacing", 32'(p0[k] - p0[k-1]), 32'd3);
      for (int k = 1; k < p1.size(); k++)
         checkOutput("held d1 spacing", 32'(p1[k] - p1[k-1]), 32'd2);

      $display("[TB] reset during a pending store");
      runAccess("sw20", 1'b1, 32'h20, 32'h11111111, rd0, rd1, e0, e1);
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post-reset d0 ready", 32'(wReady[0]), 32'd1);
      checkOutput("post-reset d1 ready", 32'(wReady[1]), 32'd1);
      checkOutput("post-reset d0 valid", 32'(wValid[0]), 32'd0);
      @(negedge clk);
      checkOutput("post-reset d0 valid+1", 32'(wValid[0]), 32'd0);
      runAccess("lw20", 1'b0, 32'h20, 32'd0, rd0, rd1, e0, e1);
      checkOutput("lw20 d0 rdata", rd0, 32'h11111111);
      checkOutput("lw20 d1 rdata", rd1, 32'h12345678);
      settle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
